sd_blockdev: RTL and testbench
==============================

// Module: sd_blockdev
// PURPOSE
//  Core-side initiator for the hps_io virtual-disk (sd_*) interface: Wishbone slave on the CPU data bus
//  (behind the IO mmu) with a 512-byte sector buffer. CPU loads LBA, issues READ/WRITE; block drives
//  sd_rd/sd_wr, moves bytes over sd_buff_*, then flags DONE and optionally interrupts. One instance per drive.
// PARAMETERS
//  TIMEOUT  24'hFFFFFF  cycles from request to sd_ack rise before abort (only with SDBLK_TIMEOUT_EN)
// PORTS
//  clk_i          in   1   system clock (clk_sys); single clock domain
//  rst_i          in   1   synchronous, active-high reset
//  bus            if_wb.slave  32-bit Wishbone slave (adr word index, dat_i/dat_o, sel[3:0], we, cyc, stb, ack)
//  sd_lba         out  32  sector number to hps_io
//  sd_rd          out  1   read request, held until sd_ack rises
//  sd_wr          out  1   write request, held until sd_ack rises
//  sd_ack         in   1   high while hps_io services the request
//  sd_buff_addr   in   9   byte address within sector
//  sd_buff_dout   in   8   byte from HPS (disk read)
//  sd_buff_wr     in   1   strobe: write sd_buff_dout at sd_buff_addr
//  sd_buff_din    out  8   byte to HPS (disk write); registered, 1 cycle after sd_buff_addr
//  img_mounted    in   1   one-cycle pulse: image (re)mounted
//  img_readonly   in   1   image is read-only
//  img_size       in   64  image size in bytes, valid with img_mounted
//  interrupt      out  1   level: DONE & IE
// BEHAVIOUR
//  Register map (word adr[7:0]): 0x00 CTRL/STAT, 0x01 LBA (R/W), 0x02 SIZE (R, sectors), 0x80-0xFF buffer.
//  CTRL write: [0] START_RD, [1] START_WR (self-clearing), [2] IE (R/W), [9] DONE W1C, [10] ERR W1C.
//  STAT read: [2] IE, [8] BUSY, [9] DONE, [10] ERR, [11] MOUNTED, [12] RO; other bits 0.
//  Wishbone: ack registered, asserted 1 cycle after cyc&stb, dropped next cycle; dat_o valid with ack;
//   writes honour sel[3:0]; unmapped addresses ack with dat_o=0, writes discarded.
//  Buffer: 4 byte lanes x 128; big-endian: byte n at word n[8:2], lane n[1:0]=0 -> dat[31:24].
//  SIZE latched on img_mounted = img_size[40:9]; MOUNTED = (img_size!=0) at that pulse; RO latched too.
//  FSM: IDLE -> REQ on valid start (LBA copied to sd_lba, BUSY=1, sd_rd or sd_wr=1).
//   REQ -> XFER on sd_ack rise (request dropped same cycle). XFER -> IDLE on sd_ack fall; DONE=1, BUSY=0.
//   DRAIN (entered after reset): wait for sd_ack=0, then IDLE; starts rejected while in DRAIN.
//  Start rejected (ERR=1, no request, state unchanged) if: not MOUNTED; START_WR with RO=1;
//   both start bits set; LBA >= SIZE. Start while BUSY ignored, no flag change.
//  sd_buff_wr updates buffer only in XFER with read op; otherwise ignored.
//  During BUSY: CPU buffer writes discarded (still acked); reads return current contents.
//  Same-cycle DONE set and W1C of DONE: set wins.
//  Reset: sd_rd=sd_wr=0, sd_lba=0, BUSY=DONE=ERR=IE=0, MOUNTED=RO=0, SIZE=0, ack=0, interrupt=0,
//   state=DRAIN; buffer contents not cleared. Reset mid-transfer abandons op; no DONE.
//  img_mounted during BUSY: SIZE/MOUNTED/RO update; current op runs to completion.
// CONFIGURATION
//  SDBLK_TIMEOUT_EN defined: counter runs in REQ; reaching TIMEOUT drops sd_rd/sd_wr, sets ERR,
//   returns to DRAIN; no DONE. Undefined: REQ waits indefinitely, no counter logic.
// TESTING
//  Mount 1 MiB image, LBA=5, write CTRL=0x1 -> sd_rd=1, sd_lba=5; HPS model acks, writes 0x00..0xFF x2;
//   DONE=1, word 0x80 reads 0x00010203, word 0xFF reads 0xFCFDFEFF.
//  CPU fills buffer, START_WR on RO=0 -> sd_wr=1; model reads sd_buff_din 1 cycle after addr, matches
//   big-endian bytes; RO=1 image -> ERR=1, sd_wr never asserted.
//  IE=1, op completes -> interrupt=1; write CTRL bit9=1 -> interrupt=0 next cycle.
//  LBA=2048 on 1 MiB image (SIZE=2048) -> ERR; no mount -> ERR; START while BUSY -> ignored, LBA unchanged.
//  Assert rst_i while sd_ack=1 -> requests 0, state DRAIN; START rejected until sd_ack=0, then accepted.
//  With SDBLK_TIMEOUT_EN, TIMEOUT=100, no ack -> sd_rd falls after 100 cycles, ERR=1, DONE=0.

Source files
------------

// File: rtl/sd_blockdev.sv
// sd_blockdev: core-side initiator for the hps_io virtual-disk (sd_*) interface.
// The CPU sees a Wishbone slave with a 512-byte sector buffer. It loads an LBA and
// issues READ or WRITE. The block then raises sd_rd/sd_wr, exchanges bytes over
// sd_buff_*, sets DONE, and interrupts if IE is set.
//
// Optional feature macro: SDBLK_TIMEOUT_EN
//   Defined   -> a request that sees no sd_ack within TIMEOUT cycles is aborted (ERR).
//   Undefined -> the request waits indefinitely.
//
// Ports
//   clk_i, rst_i       system clock, synchronous active-high reset
//   bus_*              32-bit Wishbone slave (word address, byte selects, registered ack)
//   sd_lba/sd_rd/sd_wr request to hps_io, held until sd_ack rises
//   sd_ack             high while hps_io services the request
//   sd_buff_*          byte transfer port, driven by hps_io
//   img_*              mount notification from hps_io
//   interrupt          level, DONE & IE
//
// Register map (word address):
//   0x00 CTRL/STAT, 0x01 LBA, 0x02 SIZE (sectors), 0x80-0xFF sector buffer (big-endian)
module sd_blockdev #(
    parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  bus_adr,
    input  logic [31:0] bus_dat_i,
    output logic [31:0] bus_dat_o,
    input  logic [3:0]  bus_sel,
    input  logic        bus_we,
    input  logic        bus_cyc,
    input  logic        bus_stb,
    output logic        bus_ack,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [63:0] img_size,
    output logic        interrupt
);

    typedef enum logic [1:0] {
        ST_DRAIN,
        ST_IDLE,
        ST_REQ,
        ST_XFER
    } state_t;

    state_t state, state_next;

    logic [31:0] lba;
    logic [31:0] size;
    logic        mounted, ro, ie, done, err, op_wr;
    logic [31:0] buffer [128];

    logic        bus_req, wr_req, ctrl_wr, lba_wr, cpu_buf_wr, sd_fill;
    logic        start_rd, start_wr, start_bad, busy;
    logic        accept, reject, done_set, abort;
    logic [31:0] rd_data;
    logic [31:0] sd_word;
    logic [4:0]  sd_bit;

`ifdef SDBLK_TIMEOUT_EN
    logic [23:0] tmo_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || state != ST_REQ)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 24'd1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Decode, start qualification and next state
    always_comb begin
        bus_req    = bus_cyc & bus_stb & ~bus_ack;
        wr_req     = bus_req & bus_we;
        ctrl_wr    = wr_req & (bus_adr == 8'h00);
        lba_wr     = wr_req & (bus_adr == 8'h01);
        start_rd   = ctrl_wr & bus_sel[0] & bus_dat_i[0];
        start_wr   = ctrl_wr & bus_sel[0] & bus_dat_i[1];
        busy       = (state == ST_REQ) || (state == ST_XFER);
        cpu_buf_wr = wr_req & bus_adr[7] & ~busy;
        sd_fill    = sd_buff_wr & (state == ST_XFER) & ~op_wr;
        start_bad  = ~mounted | (start_wr & ro) | (start_rd & start_wr) | (lba >= size);

        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        done_set   = 1'b0;
        abort      = 1'b0;

        case (state)
            ST_DRAIN: begin
                if (!sd_ack)
                    state_next = ST_IDLE;
                if (start_rd || start_wr)
                    reject = 1'b1;
            end
            ST_IDLE: begin
                if (start_rd || start_wr) begin
                    if (start_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = ST_REQ;
                    end
                end
            end
            // Level test of sd_ack is a rise here: REQ is only entered from IDLE,
            // which is only reached once sd_ack has been seen low.
            ST_REQ: begin
                if (sd_ack) begin
                    state_next = ST_XFER;
                end
`ifdef SDBLK_TIMEOUT_EN
                else if (tmo_cnt == TIMEOUT - 24'd1) begin
                    abort      = 1'b1;
                    state_next = ST_DRAIN;
                end
`endif
            end
            ST_XFER: begin
                if (!sd_ack) begin
                    done_set   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_DRAIN;
        endcase

        sd_rd     = (state == ST_REQ) & ~op_wr;
        sd_wr     = (state == ST_REQ) & op_wr;
        interrupt = done & ie;

        rd_data = '0;
        if (bus_adr[7]) begin
            rd_data = buffer[bus_adr[6:0]];
        end else begin
            case (bus_adr)
                8'h00:   rd_data = {19'd0, ro, mounted, err, done, busy, 5'd0, ie, 2'd0};
                8'h01:   rd_data = lba;
                8'h02:   rd_data = size;
                default: rd_data = '0;
            endcase
        end

        sd_word = buffer[sd_buff_addr[8:2]];
        sd_bit  = {~sd_buff_addr[1:0], 3'b000};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= ST_DRAIN;
        else
            state <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sd_lba  <= '0;
            lba     <= '0;
            size    <= '0;
            mounted <= 1'b0;
            ro      <= 1'b0;
            ie      <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            op_wr   <= 1'b0;
        end else begin
            if (accept) begin
                sd_lba <= lba;
                op_wr  <= start_wr;
            end
            if (lba_wr) begin
                for (int unsigned l = 0; l < 4; l++)
                    if (bus_sel[l])
                        lba[8*l +: 8] <= bus_dat_i[8*l +: 8];
            end
            if (ctrl_wr && bus_sel[0])
                ie <= bus_dat_i[2];
            // Flag set takes priority over a same-cycle W1C
            if (done_set)
                done <= 1'b1;
            else if (ctrl_wr && bus_sel[1] && bus_dat_i[9])
                done <= 1'b0;
            if (reject || abort)
                err <= 1'b1;
            else if (ctrl_wr && bus_sel[1] && bus_dat_i[10])
                err <= 1'b0;
            if (img_mounted) begin
                size    <= img_size[40:9];
                mounted <= |img_size;
                ro      <= img_readonly;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_ack   <= 1'b0;
            bus_dat_o <= '0;
        end else begin
            bus_ack <= bus_req;
            if (bus_req)
                bus_dat_o <= rd_data;
        end
    end

    // Sector buffer: not cleared by reset. CPU and hps_io writes never coincide
    // because CPU writes are discarded while an operation is in flight.
    always_ff @(posedge clk_i) begin
        if (cpu_buf_wr) begin
            for (int unsigned l = 0; l < 4; l++)
                if (bus_sel[l])
                    buffer[bus_adr[6:0]][8*l +: 8] <= bus_dat_i[8*l +: 8];
        end
        if (sd_fill)
            buffer[sd_buff_addr[8:2]][sd_bit +: 8] <= sd_buff_dout;
        sd_buff_din <= sd_word[sd_bit +: 8];
    end

endmodule

// File: tb/tb_sd_blockdev.sv
module tb_sd_blockdev;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  bus_adr;
    logic [31:0] bus_dat_i;
    logic [31:0] bus_dat_o;
    logic [3:0]  bus_sel;
    logic        bus_we, bus_cyc, bus_stb, bus_ack;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic        img_mounted, img_readonly;
    logic [63:0] img_size;
    logic        interrupt;

    always #5 clk_i = ~clk_i;

`ifdef SDBLK_TIMEOUT_EN
    localparam logic [23:0] TMO = 24'd100;
`else
    localparam logic [23:0] TMO = 24'hFFFFFF;
`endif

    sd_blockdev #(.TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .bus_adr(bus_adr), .bus_dat_i(bus_dat_i), .bus_dat_o(bus_dat_o),
        .bus_sel(bus_sel), .bus_we(bus_we), .bus_cyc(bus_cyc), .bus_stb(bus_stb),
        .bus_ack(bus_ack),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
        .interrupt(interrupt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model: operation-level view of the block
    bit          m_busy, m_req, m_op_wr, m_done, m_err, m_ie, m_mounted, m_ro, m_drain;
    logic [31:0] m_lba, m_sd_lba, m_size;
    logic [7:0]  m_mem [512];
    bit          cmp_en = 0;
    bit          din_chk = 0;
    logic [7:0]  exp_din;
    logic [31:0] d;

    function automatic logic [31:0] m_stat();
        return {19'd0, m_ro, m_mounted, m_err, m_done, m_busy, 5'd0, m_ie, 2'd0};
    endfunction

    function automatic logic [31:0] m_word(input int i);
        return {m_mem[4*i], m_mem[4*i+1], m_mem[4*i+2], m_mem[4*i+3]};
    endfunction

    always @(negedge clk_i) begin
        if (cmp_en) begin
            chk("sd_rd", 32'(sd_rd), 32'(m_req & ~m_op_wr));
            chk("sd_wr", 32'(sd_wr), 32'(m_req & m_op_wr));
            chk("sd_lba", sd_lba, m_sd_lba);
            chk("interrupt", 32'(interrupt), 32'(m_done & m_ie));
            if (din_chk)
                chk("sd_buff_din", 32'(sd_buff_din), 32'(exp_din));
        end
    end

    task automatic model_write(input logic [7:0] adr, input logic [3:0] sel, input logic [31:0] dv);
        bit set_err = 0;
        if (adr == 8'h00) begin
            if (sel[0] && (dv[0] || dv[1]) && !m_busy) begin
                if (m_drain || !m_mounted || (dv[1] && m_ro) || (dv[0] && dv[1]) || m_lba >= m_size)
                    set_err = 1;
                else begin
                    m_busy = 1; m_req = 1; m_op_wr = dv[1]; m_sd_lba = m_lba;
                end
            end
            if (sel[0]) m_ie = dv[2];
            if (sel[1] && dv[9]) m_done = 0;
            if (set_err) m_err = 1;
            else if (sel[1] && dv[10]) m_err = 0;
        end else if (adr == 8'h01) begin
            for (int k = 0; k < 4; k++)
                if (sel[k]) m_lba[8*k +: 8] = dv[8*k +: 8];
        end else if (adr[7] && !m_busy) begin
            for (int k = 0; k < 4; k++)
                if (sel[3-k]) m_mem[{adr[6:0], 2'(k)}] = dv[31-8*k -: 8];
        end
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge
    task automatic wb_cycle(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                            input logic [31:0] dv, output logic [31:0] rd);
        bus_cyc = 1; bus_stb = 1; bus_we = we; bus_adr = adr; bus_sel = sel; bus_dat_i = dv;
        @(posedge clk_i);
        if (we) model_write(adr, sel, dv);
        @(negedge clk_i);
        chk("wb_ack", 32'(bus_ack), 32'd1);
        rd = bus_dat_o;
        bus_cyc = 0; bus_stb = 0; bus_we = 0;
        @(posedge clk_i); #1;
    endtask

    task automatic wb_wr(input logic [7:0] adr, input logic [3:0] sel, input logic [31:0] dv);
        logic [31:0] unused_rd;
        wb_cycle(1'b1, adr, sel, dv, unused_rd);
    endtask

    task automatic wb_rd_chk(input string name, input logic [7:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        wb_cycle(1'b0, adr, 4'hF, 32'd0, rd);
        chk(name, rd, exp);
    endtask

    task automatic check_buffer();
        for (int i = 0; i < 128; i++)
            wb_rd_chk("buffer_word", 8'(8'h80 + i), m_word(i));
    endtask

    task automatic mount(input logic [63:0] sz, input logic rov);
        img_size = sz; img_readonly = rov; img_mounted = 1;
        @(posedge clk_i);
        m_size = sz[40:9]; m_mounted = (sz != 0); m_ro = rov;
        #1 img_mounted = 0;
    endtask

    task automatic do_reset();
        rst_i = 1;
        @(posedge clk_i);
        m_busy = 0; m_req = 0; m_op_wr = 0; m_done = 0; m_err = 0; m_ie = 0;
        m_mounted = 0; m_ro = 0; m_size = 0; m_lba = 0; m_sd_lba = 0; m_drain = 1;
        cmp_en = 1;
        #1 rst_i = 0;
        @(posedge clk_i);
        if (!sd_ack) m_drain = 0;
        #1;
    endtask

    task automatic hps_ack_up();
        sd_ack = 1;
        @(posedge clk_i);
        m_req = 0;
        #1;
    endtask

    task automatic hps_ack_down();
        sd_ack = 0;
        @(posedge clk_i);
        if (m_busy) begin m_busy = 0; m_done = 1; end
        m_drain = 0;
        #1;
    endtask

    // HPS delivers bytes 0,1,2.. at addresses 0.. (value = address mod 256)
    task automatic hps_fill(input int cnt);
        for (int n = 0; n < cnt; n++) begin
            sd_buff_addr = 9'(n); sd_buff_dout = 8'(n); sd_buff_wr = 1;
            @(posedge clk_i);
            if (m_busy && !m_req && !m_op_wr) m_mem[n] = 8'(n);
            #1;
        end
        sd_buff_wr = 0;
    endtask

    // HPS reads the sector; stray write strobes with junk data must be ignored
    task automatic hps_read_out();
        for (int n = 0; n < 512; n++) begin
            sd_buff_addr = 9'(n); sd_buff_dout = 8'hEE; sd_buff_wr = 1;
            @(posedge clk_i);
            exp_din = m_mem[n];
            din_chk = 1;
            if (m_busy && !m_req && !m_op_wr) m_mem[n] = 8'hEE;
            #1;
        end
        sd_buff_wr = 0;
        din_chk = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        rst_i = 1; bus_adr = '0; bus_dat_i = '0; bus_sel = '0; bus_we = 0; bus_cyc = 0;
        bus_stb = 0; sd_ack = 0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 0;
        img_mounted = 0; img_readonly = 0; img_size = '0;
        #1;
        do_reset();

        // Reset state
        wb_rd_chk("stat_reset", 8'h00, 32'h0000_0000);
        wb_rd_chk("size_reset", 8'h02, 32'h0000_0000);
        wb_rd_chk("lba_reset", 8'h01, 32'h0000_0000);

        // Start with no image mounted
        wb_wr(8'h00, 4'h1, 32'h1);
        wb_rd_chk("stat_nomount", 8'h00, 32'h0000_0400);
        wb_wr(8'h00, 4'h2, 32'h400);
        wb_rd_chk("stat_err_clr", 8'h00, m_stat());

        // Mount 1 MiB image
        mount(64'h10_0000, 1'b0);
        wb_rd_chk("size_1mib", 8'h02, 32'd2048);
        wb_rd_chk("stat_mounted", 8'h00, 32'h0000_0800);

        // LBA == SIZE is out of range
        wb_wr(8'h01, 4'hF, 32'd2048);
        wb_wr(8'h00, 4'h1, 32'h1);
        wb_rd_chk("stat_lba_oob", 8'h00, 32'h0000_0C00);
        wb_wr(8'h00, 4'h2, 32'h400);

        // Both start bits set
        wb_wr(8'h01, 4'hF, 32'd5);
        wb_wr(8'h00, 4'h1, 32'h3);
        wb_rd_chk("stat_both", 8'h00, m_stat());
        wb_wr(8'h00, 4'h2, 32'h400);
        wb_rd_chk("lba_reg", 8'h01, 32'd5);

        // Sector read with IE
        wb_wr(8'h00, 4'h1, 32'h5);
        chk("sd_rd_up", 32'(sd_rd), 32'd1);
        chk("sd_lba_5", sd_lba, 32'd5);
        wb_rd_chk("stat_busy", 8'h00, 32'h0000_0904);

        // Start while busy: ignored
        wb_wr(8'h01, 4'hF, 32'd7);
        wb_wr(8'h00, 4'h1, 32'h5);
        wb_rd_chk("stat_busy_ign", 8'h00, m_stat());
        chk("sd_lba_held", sd_lba, 32'd5);

        hps_ack_up();
        hps_fill(512);
        hps_ack_down();
        wb_rd_chk("stat_done", 8'h00, 32'h0000_0A04);
        chk("irq_done", 32'(interrupt), 32'd1);
        wb_rd_chk("word_80", 8'h80, 32'h0001_0203);
        wb_rd_chk("word_ff", 8'hFF, 32'hFCFD_FEFF);
        check_buffer();

        // W1C DONE drops the interrupt
        wb_wr(8'h00, 4'h2, 32'h200);
        chk("irq_cleared", 32'(interrupt), 32'd0);

        // CPU fills the buffer, including a partial-lane write
        for (int i = 0; i < 128; i++)
            wb_wr(8'(8'h80 + i), 4'hF, 32'h1122_3344 + 32'(i) * 32'h0103_0507);
        wb_wr(8'h81, 4'b0101, 32'hDEAD_BEEF);
        check_buffer();

        // Sector write (LBA register holds 7, IE cleared)
        wb_wr(8'h00, 4'h1, 32'h2);
        chk("sd_wr_up", 32'(sd_wr), 32'd1);
        wb_wr(8'h90, 4'hF, 32'h0BAD_F00D);
        hps_ack_up();
        hps_read_out();
        hps_ack_down();
        wb_rd_chk("stat_wr_done", 8'h00, m_stat());
        check_buffer();

        // Strobes outside a transfer are ignored
        hps_fill(4);
        wb_rd_chk("idle_fill", 8'h80, m_word(0));

        // Unmapped addresses
        wb_wr(8'h03, 4'hF, 32'hFFFF_FFFF);
        wb_rd_chk("unmapped_03", 8'h03, 32'h0);
        wb_rd_chk("unmapped_7f", 8'h7F, 32'h0);

        // Read-only image rejects a write
        mount(64'h10_0000, 1'b1);
        wb_wr(8'h00, 4'h2, 32'h200);
        wb_wr(8'h00, 4'h1, 32'h2);
        wb_rd_chk("stat_ro_rej", 8'h00, 32'h0000_1C00);

        // Remount while busy: SIZE updates, op completes
        mount(64'h10_0000, 1'b0);
        wb_wr(8'h00, 4'h2, 32'h400);
        wb_wr(8'h00, 4'h1, 32'h1);
        mount(64'h20_0000, 1'b0);
        wb_rd_chk("size_remount", 8'h02, 32'd4096);
        hps_ack_up();
        hps_fill(512);
        hps_ack_down();
        wb_rd_chk("stat_remount_done", 8'h00, m_stat());

        // Reset mid-transfer with sd_ack held high
        wb_wr(8'h00, 4'h3, 32'h600);
        wb_wr(8'h00, 4'h1, 32'h1);
        hps_ack_up();
        hps_fill(8);
        do_reset();
        chk("rst_sd_rd", 32'(sd_rd), 32'd0);
        wb_rd_chk("stat_rst_mid", 8'h00, 32'h0000_0000);
        mount(64'h10_0000, 1'b0);
        wb_wr(8'h00, 4'h1, 32'h1);
        wb_rd_chk("stat_drain_rej", 8'h00, 32'h0000_0C00);
        hps_ack_down();
        wb_wr(8'h00, 4'h2, 32'h400);
        wb_wr(8'h00, 4'h1, 32'h1);
        wb_rd_chk("stat_after_drain", 8'h00, 32'h0000_0900);
        hps_ack_up();
        hps_fill(512);
        hps_ack_down();
        wb_rd_chk("stat_final_done", 8'h00, 32'h0000_0A00);

`ifdef SDBLK_TIMEOUT_EN
        // No ack: request drops after TIMEOUT cycles, ERR set, no DONE
        wb_wr(8'h00, 4'h2, 32'h600);
        wb_wr(8'h00, 4'h1, 32'h1);
        for (int i = 1; i < 100; i++) begin
            @(posedge clk_i); #1;
        end
        @(posedge clk_i);
        m_req = 0; m_busy = 0; m_err = 1; m_drain = 1;
        #1;
        @(posedge clk_i);
        m_drain = 0;
        #1;
        wb_rd_chk("stat_timeout", 8'h00, 32'h0000_0C00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
